// File: rtl/axi_lite_to_ahb_bridge.sv
// AXI4-Lite slave to AHB-Lite master bridge: one outstanding AXI read or write
// is turned into a single AHB-Lite transfer, and the AHB response is returned
// as RRESP/BRESP.
module axi_lite_to_ahb_bridge #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // AXI4-Lite write address / data / response
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  // AXI4-Lite read address / data
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  // AHB-Lite master
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic [31:0]           hwdata,
  input  logic [31:0]           hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  typedef enum logic [2:0] {
    StIdle, StWaddr, StWdata, StBresp, StRaddr, StRdata, StRresp
  } state_e;

  state_e                state_q, state_d;
  logic                  last_wr_q;  // 1: the most recent grant went to the write side
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic [2:0]            hsize_q;
  logic [3:0]            hprot_q;
  logic                  hwrite_q;
  logic [31:0]           hwdata_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [31:0]           rdata_q;

  logic       wr_elig, rd_elig, grant_wr, grant_rd;
  logic       strb_ok;
  logic [2:0] strb_size;
  logic [1:0] strb_lo;

  // axprot[1] (secure/non-secure) has no AHB-Lite counterpart
  logic unused_prot;
  assign unused_prot = ^{awprot[1], arprot[1]};

  // Round-robin grant, only in IDLE; write needs both address and data present
  always_comb begin
    wr_elig  = awvalid & wvalid;
    rd_elig  = arvalid;
    grant_wr = (state_q == StIdle) & wr_elig & (~rd_elig | ~last_wr_q);
    grant_rd = (state_q == StIdle) & rd_elig & ~grant_wr;
  end

  // Map the write strobe onto an AHB size and low address bits
  always_comb begin
    strb_ok   = 1'b1;
    strb_size = 3'b010;
    strb_lo   = 2'b00;
    case (wstrb)
      4'b1111: ;
      4'b0011: strb_size = 3'b001;
      4'b1100: begin strb_size = 3'b001; strb_lo = 2'b10; end
      4'b0001: strb_size = 3'b000;
      4'b0010: begin strb_size = 3'b000; strb_lo = 2'b01; end
      4'b0100: begin strb_size = 3'b000; strb_lo = 2'b10; end
      4'b1000: begin strb_size = 3'b000; strb_lo = 2'b11; end
      default: strb_ok = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_wr)      state_d = strb_ok ? StWaddr : StBresp;
        else if (grant_rd) state_d = StRaddr;
      end
      StWaddr: if (hready) state_d = StWdata;
      StWdata: if (hready) state_d = StBresp;
      StBresp: if (bready) state_d = StIdle;
      StRaddr: if (hready) state_d = StRdata;
      StRdata: if (hready) state_d = StRresp;
      StRresp: if (rready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Request capture at grant, response capture on the last data-phase cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr_q <= 1'b0;
      haddr_q   <= '0;
      hsize_q   <= 3'b010;
      hprot_q   <= 4'b0000;
      hwrite_q  <= 1'b0;
      hwdata_q  <= 32'h0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0;
    end else begin
      if (grant_wr) begin
        last_wr_q <= 1'b1;
        haddr_q   <= {awaddr[ADDR_WIDTH-1:2], strb_lo};
        hsize_q   <= strb_size;
        hprot_q   <= {2'b00, awprot[0], ~awprot[2]};
        hwrite_q  <= 1'b1;
        hwdata_q  <= wdata;
        // Unsupported strobe skips the AHB side entirely
        if (!strb_ok) bresp_q <= 2'b10;
      end
      if (grant_rd) begin
        last_wr_q <= 1'b0;
        haddr_q   <= {araddr[ADDR_WIDTH-1:2], 2'b00};
        hsize_q   <= 3'b010;
        hprot_q   <= {2'b00, arprot[0], ~arprot[2]};
        hwrite_q  <= 1'b0;
      end
      if (state_q == StWdata && hready) bresp_q <= hresp ? 2'b10 : 2'b00;
      if (state_q == StRdata && hready) begin
        rresp_q <= hresp ? 2'b10 : 2'b00;
        rdata_q <= hrdata;
      end
    end
  end

  // Output drive
  always_comb begin
    awready = grant_wr;
    wready  = grant_wr;
    arready = grant_rd;
    bvalid  = (state_q == StBresp);
    bresp   = bresp_q;
    rvalid  = (state_q == StRresp);
    rresp   = rresp_q;
    rdata   = rdata_q;
    htrans  = (state_q == StWaddr || state_q == StRaddr) ? 2'b10 : 2'b00;
    haddr   = haddr_q;
    hwrite  = hwrite_q;
    hsize   = hsize_q;
    hburst  = 3'b000;
    hprot   = hprot_q;
    hwdata  = hwdata_q;
  end

endmodule

// File: tb/tb_axi_lite_to_ahb_bridge.sv
// Self-checking bench for axi_lite_to_ahb_bridge: directed scenarios plus
// randomized transactions against a transaction-level expectation model.
module tb_axi_lite_to_ahb_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] awaddr, araddr, wdata, rdata, haddr, hwdata, hrdata;
  logic [2:0]  awprot, arprot, hsize, hburst;
  logic [3:0]  wstrb, hprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, hwrite, hready, hresp;
  logic [1:0]  bresp, rresp, htrans;

  int n_tests = 0;
  int n_fail  = 0;

  axi_lite_to_ahb_bridge #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe rules: full word, aligned halfword, or single byte; anything else rejected
  task automatic strb_model(input logic [3:0] s, output bit ok, output logic [2:0] sz,
                            output logic [1:0] lo);
    int n;
    n  = $countones(s);
    ok = (n == 1) || (s == 4'hF) || (s == 4'h3) || (s == 4'hC);
    sz = (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
    lo = 2'd0;
    for (int b = 3; b >= 0; b--) if (s[b]) lo = 2'(b);
  endtask

  function automatic logic [3:0] prot_model(input logic [2:0] p);
    return {2'b00, p[0], ~p[2]};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    hready = 1; hresp = 0; hrdata = 32'h0;
    step(); step();
    reset = 1'b0;
  endtask

  // Everything after the write handshake: AHB phases, then the B channel
  task automatic wr_body(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] s,
                         input logic [2:0] prot, input int wa, input int wd, input bit err,
                         input int bw);
    bit ok; logic [2:0] sz; logic [1:0] lo;
    strb_model(s, ok, sz, lo);
    if (!ok) begin
      chk("wr_bad_htrans", htrans, 2'b00);
      chk("wr_bad_bvalid", bvalid, 1'b1);
      chk("wr_bad_bresp", bresp, 2'b10);
    end else begin
      for (int i = 0; i <= wa; i++) begin
        hready = (i == wa); hresp = 0; #1;
        chk("wa_htrans", htrans, 2'b10);
        chk("wa_haddr", haddr, {addr[31:2], lo});
        chk("wa_hsize", hsize, sz);
        chk("wa_hwrite", hwrite, 1'b1);
        chk("wa_hprot", hprot, prot_model(prot));
        chk("wa_hburst", hburst, 3'b000);
        chk("wa_readys", {awready, wready, arready}, 3'b000);
        step();
      end
      for (int i = 0; i <= wd; i++) begin
        hready = (i == wd); hresp = err && (i >= wd - 1); #1;
        chk("wd_htrans", htrans, 2'b00);
        chk("wd_hwdata", hwdata, data);
        step();
      end
      hready = 1; hresp = 0;
      chk("wr_bvalid", bvalid, 1'b1);
      chk("wr_bresp", bresp, err ? 2'b10 : 2'b00);
    end
    for (int i = 0; i < bw; i++) begin
      step();
      chk("wr_bhold_valid", bvalid, 1'b1);
      chk("wr_bhold_resp", bresp, (!ok || err) ? 2'b10 : 2'b00);
      chk("wr_bhold_htrans", htrans, 2'b00);
    end
    bready = 1;
    step();
    bready = 0;
    chk("wr_bdone", bvalid, 1'b0);
  endtask

  task automatic wr_xfer(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] s,
                         input logic [2:0] prot, input int wa, input int wd, input bit err,
                         input int bw);
    awaddr = addr; wdata = data; wstrb = s; awprot = prot;
    awvalid = 1; wvalid = 1; #1;
    chk("wr_hs", {awready, wready, arready}, 3'b110);
    step();
    chk("wr_busy_ready", {awready, wready}, 2'b00);
    awvalid = 0; wvalid = 0;
    wr_body(addr, data, s, prot, wa, wd, err, bw);
  endtask

  // Everything after the read handshake: AHB phases, then the R channel
  task automatic rd_body(input logic [31:0] addr, input logic [2:0] prot, input int wa,
                         input int wd, input bit err, input int rw, input logic [31:0] data);
    for (int i = 0; i <= wa; i++) begin
      hready = (i == wa); hresp = 0; #1;
      chk("ra_htrans", htrans, 2'b10);
      chk("ra_haddr", haddr, {addr[31:2], 2'b00});
      chk("ra_hsize", hsize, 3'b010);
      chk("ra_hwrite", hwrite, 1'b0);
      chk("ra_hprot", hprot, prot_model(prot));
      chk("ra_readys", {awready, wready, arready}, 3'b000);
      step();
    end
    for (int i = 0; i <= wd; i++) begin
      hready = (i == wd); hresp = err && (i >= wd - 1);
      hrdata = (i == wd) ? data : $urandom; #1;
      chk("rd_htrans", htrans, 2'b00);
      chk("rd_rvalid_early", rvalid, 1'b0);
      step();
    end
    hready = 1; hresp = 0; hrdata = $urandom;
    chk("rd_rvalid", rvalid, 1'b1);
    chk("rd_rdata", rdata, data);
    chk("rd_rresp", rresp, err ? 2'b10 : 2'b00);
    for (int i = 0; i < rw; i++) begin
      hrdata = $urandom;
      step();
      chk("rd_hold_valid", rvalid, 1'b1);
      chk("rd_hold_data", rdata, data);
      chk("rd_hold_resp", rresp, err ? 2'b10 : 2'b00);
    end
    rready = 1;
    step();
    rready = 0;
    chk("rd_done", rvalid, 1'b0);
  endtask

  task automatic rd_xfer(input logic [31:0] addr, input logic [2:0] prot, input int wa,
                         input int wd, input bit err, input int rw, input logic [31:0] data);
    araddr = addr; arprot = prot; arvalid = 1; #1;
    chk("rd_hs", {awready, wready, arready}, 3'b001);
    step();
    chk("rd_busy_ready", arready, 1'b0);
    arvalid = 0;
    rd_body(addr, prot, wa, wd, err, rw, data);
  endtask

  initial begin
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 0; arprot = 0;
    do_reset();

    // Reset values
    chk("rst_readys", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resps", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_hwrite", hwrite, 1'b0);
    chk("rst_hsize", hsize, 3'b010);
    chk("rst_hburst", hburst, 3'b000);
    chk("rst_hprot", hprot, 4'b0000);
    chk("rst_hwdata", hwdata, 32'h0);

    // Word write, byte write, invalid strobe
    wr_xfer(32'h1000, 32'hDEADBEEF, 4'b1111, 3'b000, 0, 0, 0, 0);
    wr_xfer(32'h2000, 32'h00AB0000, 4'b0100, 3'b001, 0, 0, 0, 1);
    wr_xfer(32'h2000, 32'h11223344, 4'b0101, 3'b000, 0, 0, 0, 2);
    wr_xfer(32'h2004, 32'h0000CAFE, 4'b0000, 3'b000, 0, 0, 0, 0);
    wr_xfer(32'h2008, 32'hBEEF0000, 4'b1100, 3'b101, 1, 0, 0, 0);

    // Read with data-phase wait states and a slow rready
    rd_xfer(32'h3006, 3'b000, 0, 3, 0, 4, 32'h12345678);

    // Two-cycle AHB error on both directions
    rd_xfer(32'h4000, 3'b100, 0, 1, 1, 0, 32'hA5A5A5A5);
    wr_xfer(32'h4010, 32'h01020304, 4'b1111, 3'b001, 0, 1, 1, 0);

    // Half-present write is never accepted; a read may pass it
    awaddr = 32'h5000; wstrb = 4'hF; awvalid = 1; wvalid = 0; #1;
    chk("half_aw", {awready, wready}, 2'b00);
    step();
    awvalid = 0; wvalid = 1; #1;
    chk("half_w", {awready, wready}, 2'b00);
    step();
    wvalid = 0; awvalid = 1;
    rd_xfer(32'h5100, 3'b001, 0, 0, 0, 0, 32'h0BADF00D);
    awvalid = 0;

    // Arbitration: write first after reset, then read wins with both pending
    do_reset();
    awaddr = 32'h6000; wdata = 32'h600D600D; wstrb = 4'hF; awprot = 3'b000;
    araddr = 32'h6100; arprot = 3'b000;
    awvalid = 1; wvalid = 1; arvalid = 1; #1;
    chk("arb1_grant", {awready, wready, arready}, 3'b110);
    step();
    awvalid = 0; wvalid = 0;
    wr_body(32'h6000, 32'h600D600D, 4'hF, 3'b000, 0, 0, 0, 0);
    awaddr = 32'h6200; wdata = 32'h00000077; wstrb = 4'b0001;
    awvalid = 1; wvalid = 1; #1;
    chk("arb2_grant", {awready, wready, arready}, 3'b001);
    step();
    arvalid = 0;
    rd_body(32'h6100, 3'b000, 0, 0, 0, 0, 32'h61616161);
    #1;
    chk("arb3_grant", {awready, wready, arready}, 3'b110);
    step();
    awvalid = 0; wvalid = 0;
    wr_body(32'h6200, 32'h00000077, 4'b0001, 3'b000, 0, 0, 0, 0);

    // Reset during the write data phase
    awaddr = 32'h7000; wdata = 32'h77777777; wstrb = 4'hF; awprot = 3'b111;
    awvalid = 1; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0; hready = 1;
    step();
    chk("rstmid_in_wdata", htrans, 2'b00);
    hready = 0; reset = 1;
    step();
    reset = 0; hready = 1;
    chk("rstmid_htrans", htrans, 2'b00);
    chk("rstmid_bvalid", bvalid, 1'b0);
    chk("rstmid_readys", {awready, wready, arready}, 3'b000);
    chk("rstmid_hwdata", hwdata, 32'h0);
    step();
    chk("rstmid_no_b", bvalid, 1'b0);
    rd_xfer(32'h7104, 3'b000, 0, 0, 0, 0, 32'hFEEDFACE);

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      logic [2:0]  p;
      int wa, wd, hw;
      bit err;
      a = $urandom; d = $urandom; s = 4'($urandom); p = 3'($urandom);
      err = ($urandom_range(0, 3) == 0);
      wa = $urandom_range(0, 2);
      wd = err ? $urandom_range(1, 3) : $urandom_range(0, 2);
      hw = $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0) s = 4'hF;
      if ($urandom_range(0, 1) == 1) wr_xfer(a, d, s, p, wa, wd, err, hw);
      else                           rd_xfer(a, p, wa, wd, err, hw, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
